// File: rtl/if_trace_queue.sv
// if_trace_queue: instruction-fetch trace stage. Captures load/store fetches,
// confirms each one on the next fetch response if no jump intervened, and
// queues the confirmed fetches with their fetch timestamp in a DEPTH-entry FIFO.
//   clk, rst_n        : clock, asynchronous active-low reset
//   jump_done         : branch/jump redirect taken (cancels the pending capture)
//   instr_rvalid/rdata: instruction memory response
//   trace_valid_o/ready_i, trace_instr_o, trace_ts_o : FIFO head, valid/ready drain
//   fifo_level_o      : occupied FIFO entries
//   drop_count_o      : saturating count of commits lost to a full FIFO
//   clear_drops_i     : synchronous clear of drop_count_o
// Optional: define IF_TRACE_TIMESTAMP_EN to build the timestamp counter and
// per-entry timestamp storage; otherwise trace_ts_o is tied to 0.
module if_trace_queue #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int TS_WIDTH     = 32,
    parameter int CAPTURE_MODE = 0,
    parameter int DROP_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    jump_done,
    input  logic                    instr_rvalid,
    input  logic [DATA_WIDTH-1:0]   instr_rdata,
    output logic                    trace_valid_o,
    input  logic                    trace_ready_i,
    output logic [DATA_WIDTH-1:0]   trace_instr_o,
    output logic [TS_WIDTH-1:0]     trace_ts_o,
    output logic [$clog2(DEPTH):0]  fifo_level_o,
    output logic [DROP_WIDTH-1:0]   drop_count_o,
    input  logic                    clear_drops_i
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, PENDING} state_t;
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] pend_instr;
    logic pend_jump;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] level;
    logic is_load, is_store, match, hit, kill, commit, full, pop, push, drop;
    assign is_load  = instr_rdata[6:0] == 7'h03;
    assign is_store = instr_rdata[6:0] == 7'h23;
    assign match = (CAPTURE_MODE == 1) ? is_load : (CAPTURE_MODE == 2) ? is_store : (is_load || is_store);
    assign hit = instr_rvalid && match;
    // A new matching fetch always becomes the pending slot, whichever way the
    // old one was resolved (discarded by a jump or committed).
    always_comb begin
        kill    = (state == PENDING) && (pend_jump || jump_done);
        commit  = (state == PENDING) && !kill && instr_rvalid;
        state_n = hit ? PENDING : (kill || commit) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend_instr <= '0;
            pend_jump  <= 1'b0;
        end else begin
            state <= state_n;
            if (hit) begin
                pend_instr <= instr_rdata;
                pend_jump  <= (state == IDLE) && jump_done;
            end
        end
    end
    assign full = level == (AW+1)'(DEPTH);
    assign pop  = trace_valid_o && trace_ready_i;
    assign push = commit && (!full || pop);
    assign drop = commit && full && !pop;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            drop_count_o <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            level  <= level + (AW+1)'(push) - (AW+1)'(pop);
            if (clear_drops_i)
                drop_count_o <= '0;
            else if (drop && drop_count_o != '1)
                drop_count_o <= drop_count_o + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= pend_instr;
    end
    // Head outputs are masked when empty so they read 0 after reset.
    assign trace_valid_o = level != '0;
    assign trace_instr_o = trace_valid_o ? mem[rd_ptr] : '0;
    assign fifo_level_o  = level;
`ifdef IF_TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts, pend_ts;
    logic [TS_WIDTH-1:0] mem_ts [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts      <= '0;
            pend_ts <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (hit)
                pend_ts <= ts;
        end
    end
    always_ff @(posedge clk) begin
        if (push)
            mem_ts[wr_ptr] <= pend_ts;
    end
    assign trace_ts_o = trace_valid_o ? mem_ts[rd_ptr] : '0;
`else
    assign trace_ts_o = '0;
`endif
endmodule
